// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// fetch_queue_pkg : shared CPU constants (widths, reset PC, base opcodes)
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

    localparam int          CPU_XLEN     = 32;
    localparam int          CPU_ILEN     = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    // Counters must hold the value DEPTH itself, hence one bit above the index.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue_sync_fifo.sv
// ============================================================================
// sync_fifo : generic single-clock FIFO with synchronous flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : instruction fetch unit with in-flight PC tracking, buffer,
//               redirect flush and stale-response dropping
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              XLEN     = CPU_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC)
) (
    input  logic            CLK,
    input  logic            Reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4
);

    localparam int CW = cnt_width(DEPTH);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     pcq_count;
    logic [CW:0]       inflight;
    logic [XLEN-1:0]   rsp_pc;
    logic [2*XLEN-1:0] head;
    logic              req_fire;
    logic              rsp_push;
    logic              head_valid;
    logic              pop;

    // The PC FIFO holds every request not yet answered, dropped ones included,
    // so its count is outstanding + drop_cnt.
    assign inflight       = {1'b0, buf_count} + {1'b0, pcq_count};
    assign imem_req_valid = !Reset && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_push   = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign head_valid = (buf_count != '0);
    assign out_valid  = head_valid && !redirect_valid;
    assign pop        = out_valid && out_ready;

    assign out_pc       = head_valid ? head[2*XLEN-1:XLEN] : '0;
    assign out_instr    = head_valid ? head[XLEN-1:0]      : '0;
    assign out_pc_plus4 = out_pc + XLEN'(4);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc & ~(XLEN'(3));
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_q + outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_push);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk     (CLK),
        .rst     (Reset),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .wdata_i (fetch_pc_q),
        .pop_i   (imem_rsp_valid),
        .rdata_o (rsp_pc),
        .count_o (pcq_count)
    );

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk     (CLK),
        .rst     (Reset),
        .flush_i (redirect_valid),
        .push_i  (rsp_push),
        .wdata_i ({rsp_pc, imem_rsp_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (buf_count)
    );

endmodule

`default_nettype wire
